// File: rtl/div_16bit_restoring_if.sv
// Handshake and operand/result bundle for the sequential restoring divider.
interface div_16bit_restoring_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  i_start;
  logic [DATA_WIDTH-1:0] i_num_a;
  logic [DATA_WIDTH-1:0] i_num_b;
  logic                  o_busy;
  logic                  o_end;
  logic [DATA_WIDTH-1:0] o_quo;
  logic [DATA_WIDTH-1:0] o_rem;
  logic                  o_err;

  modport master (
    output i_start, i_num_a, i_num_b,
    input  o_busy, o_end, o_quo, o_rem, o_err
  );

  modport slave (
    input  i_start, i_num_a, i_num_b,
    output o_busy, o_end, o_quo, o_rem, o_err
  );
endinterface

// File: rtl/div_16bit_restoring.sv
// Sequential restoring divider: one quotient bit per clock, pulses o_end with quotient/remainder.
// Define DIV_16BIT_SIGNED_EN for two's-complement operands (truncating toward zero).
module div_16bit_restoring #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input logic                  i_clk,
  input logic                  i_rst,
  div_16bit_restoring_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]            state,   state_nxt;
  logic [CNT_W-1:0]      cnt,     cnt_nxt;
  logic [DATA_WIDTH-1:0] rem_q,   rem_nxt;
  logic [DATA_WIDTH-1:0] quo_q,   quo_nxt;
  logic [DATA_WIDTH-1:0] dvs_q,   dvs_nxt;
  logic                  busy_r,  busy_nxt;
  logic                  end_r,   end_nxt;
  logic                  err_r,   err_nxt;
  logic [DATA_WIDTH-1:0] quo_r,   quo_r_nxt;
  logic [DATA_WIDTH-1:0] rem_r,   rem_r_nxt;

  logic [DATA_WIDTH-1:0] a_mag, b_mag;
  logic [DATA_WIDTH:0]   r_shift;
  logic                  r_ge;
  logic [DATA_WIDTH-1:0] r_iter, q_iter;
  logic [DATA_WIDTH-1:0] quo_fix, rem_fix;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  assign r_shift = {rem_q, quo_q[DATA_WIDTH-1]};
  assign r_ge    = (r_shift >= {1'b0, dvs_q});
  assign r_iter  = r_ge ? DATA_WIDTH'(r_shift - {1'b0, dvs_q}) : r_shift[DATA_WIDTH-1:0];
  assign q_iter  = {quo_q[DATA_WIDTH-2:0], r_ge};

`ifdef DIV_16BIT_SIGNED_EN
  logic sq_q, sq_nxt;
  logic sr_q, sr_nxt;

  assign a_mag   = bus.i_num_a[DATA_WIDTH-1] ? ({DATA_WIDTH{1'b0}} - bus.i_num_a) : bus.i_num_a;
  assign b_mag   = bus.i_num_b[DATA_WIDTH-1] ? ({DATA_WIDTH{1'b0}} - bus.i_num_b) : bus.i_num_b;
  assign quo_fix = sq_q ? ({DATA_WIDTH{1'b0}} - q_iter) : q_iter;
  assign rem_fix = sr_q ? ({DATA_WIDTH{1'b0}} - r_iter) : r_iter;
`else
  assign a_mag   = bus.i_num_a;
  assign b_mag   = bus.i_num_b;
  assign quo_fix = q_iter;
  assign rem_fix = r_iter;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rem_nxt   = rem_q;
    quo_nxt   = quo_q;
    dvs_nxt   = dvs_q;
    busy_nxt  = busy_r;
    end_nxt   = 1'b0;
    err_nxt   = err_r;
    quo_r_nxt = quo_r;
    rem_r_nxt = rem_r;
`ifdef DIV_16BIT_SIGNED_EN
    sq_nxt    = sq_q;
    sr_nxt    = sr_q;
`endif
    case (state)
      IDLE: begin
        if (bus.i_start) begin
          quo_nxt  = a_mag;
          dvs_nxt  = b_mag;
          rem_nxt  = '0;
          cnt_nxt  = '0;
          busy_nxt = 1'b1;
`ifdef DIV_16BIT_SIGNED_EN
          sq_nxt   = bus.i_num_a[DATA_WIDTH-1] ^ bus.i_num_b[DATA_WIDTH-1];
          sr_nxt   = bus.i_num_a[DATA_WIDTH-1];
`endif
          // Divide-by-zero skips iteration and reports immediately.
          if (bus.i_num_b == '0) begin
            state_nxt = DONE;
            end_nxt   = 1'b1;
            err_nxt   = 1'b1;
            quo_r_nxt = '1;
            rem_r_nxt = bus.i_num_a;
          end else begin
            state_nxt = CALC;
          end
        end
      end
      CALC: begin
        rem_nxt = r_iter;
        quo_nxt = q_iter;
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == CNT_W'(DATA_WIDTH - 1)) begin
          state_nxt = DONE;
          end_nxt   = 1'b1;
          err_nxt   = 1'b0;
          quo_r_nxt = quo_fix;
          rem_r_nxt = rem_fix;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= IDLE;
      cnt    <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      busy_r <= 1'b0;
      end_r  <= 1'b0;
      err_r  <= 1'b0;
      quo_r  <= '0;
      rem_r  <= '0;
`ifdef DIV_16BIT_SIGNED_EN
      sq_q   <= 1'b0;
      sr_q   <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      rem_q  <= rem_nxt;
      quo_q  <= quo_nxt;
      dvs_q  <= dvs_nxt;
      busy_r <= busy_nxt;
      end_r  <= end_nxt;
      err_r  <= err_nxt;
      quo_r  <= quo_r_nxt;
      rem_r  <= rem_r_nxt;
`ifdef DIV_16BIT_SIGNED_EN
      sq_q   <= sq_nxt;
      sr_q   <= sr_nxt;
`endif
    end
  end

  assign bus.o_busy = busy_r;
  assign bus.o_end  = end_r;
  assign bus.o_err  = err_r;
  assign bus.o_quo  = quo_r;
  assign bus.o_rem  = rem_r;

endmodule

// File: tb/tb_div_16bit_restoring.sv
// Directed self-checking bench for div_16bit_restoring (signed cases run when DIV_16BIT_SIGNED_EN is defined).
module tb_div_16bit_restoring;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  div_16bit_restoring_if #(.DATA_WIDTH(16)) bus ();

  div_16bit_restoring #(.DATA_WIDTH(16)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Issue one division, then check latency, busy width, pulse width and held results.
  task automatic run(input string tag, input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] eq, input logic [15:0] er, input logic ee,
                     input int elat, input int ebusy);
    int lat;
    int busy_n;
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_num_a = a;
    bus.i_num_b = b;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    bus.i_num_a = 16'hA5C3;
    bus.i_num_b = 16'h0000;
    @(negedge clk);
    lat    = 0;
    busy_n = bus.o_busy ? 1 : 0;
    while (!bus.o_end && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.o_busy) busy_n++;
    end
    check({tag, "_lat"},  32'(lat),        32'(elat));
    check({tag, "_busy"}, 32'(busy_n),     32'(ebusy));
    check({tag, "_quo"},  32'(bus.o_quo),  32'(eq));
    check({tag, "_rem"},  32'(bus.o_rem),  32'(er));
    check({tag, "_err"},  32'(bus.o_err),  32'(ee));
    @(negedge clk);
    check({tag, "_pulse"}, 32'(bus.o_end),  32'd0);
    check({tag, "_idle"},  32'(bus.o_busy), 32'd0);
    check({tag, "_hold"},  32'({bus.o_quo, bus.o_rem}), {eq, er});
  endtask

  initial begin
    int ends;
    logic [15:0] q_seen;
    logic [15:0] r_seen;
    n_chk  = 0;
    n_pass = 0;
    rst = 1'b1;
    bus.i_start = 1'b0;
    bus.i_num_a = '0;
    bus.i_num_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(bus.o_busy), 32'd0);
    check("rst_end",  32'(bus.o_end),  32'd0);
    check("rst_res",  32'({bus.o_quo, bus.o_rem}), 32'd0);
    check("rst_err",  32'(bus.o_err),  32'd0);
    rst = 1'b0;

    run("d10_9",   16'd10,    16'd9, 16'd1,     16'd1, 1'b0, 16, 17);
    run("d10_5",   16'd10,    16'd5, 16'd2,     16'd0, 1'b0, 16, 17);
    run("dffff_1", 16'hFFFF,  16'd1, 16'hFFFF,  16'd0, 1'b0, 16, 17);
    run("d3_7",    16'd3,     16'd7, 16'd0,     16'd3, 1'b0, 16, 17);
    run("d0_5",    16'd0,     16'd5, 16'd0,     16'd0, 1'b0, 16, 17);
    run("d7_0",    16'd7,     16'd0, 16'hFFFF,  16'd7, 1'b1, 0, 1);
    run("d20_6",   16'd20,    16'd6, 16'd3,     16'd2, 1'b0, 16, 17);

    // Second start while busy must be ignored and not queued.
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_num_a = 16'd100;
    bus.i_num_b = 16'd7;
    @(posedge clk);
    #1 bus.i_start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_num_a = 16'd1;
    bus.i_num_b = 16'd1;
    @(posedge clk);
    #1 bus.i_start = 1'b0;
    ends   = 0;
    q_seen = '0;
    r_seen = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.o_end) begin
        ends++;
        q_seen = bus.o_quo;
        r_seen = bus.o_rem;
      end
    end
    check("ign_ends", 32'(ends),   32'd1);
    check("ign_quo",  32'(q_seen), 32'd14);
    check("ign_rem",  32'(r_seen), 32'd2);

    // Reset mid-operation aborts with no o_end.
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_num_a = 16'd1000;
    bus.i_num_b = 16'd3;
    @(posedge clk);
    #1 bus.i_start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(bus.o_busy), 32'd0);
    check("abort_res",  32'({bus.o_quo, bus.o_rem}), 32'd0);
    check("abort_err",  32'(bus.o_err), 32'd0);
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    ends = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus.o_end) ends++;
    end
    check("abort_noend", 32'(ends), 32'd0);
    run("d1000_3", 16'd1000, 16'd3, 16'd333, 16'd1, 1'b0, 16, 17);

`ifdef DIV_16BIT_SIGNED_EN
    run("sm7_2",   16'hFFF9, 16'd2,    16'hFFFD, 16'hFFFF, 1'b0, 16, 17);
    run("s7_m2",   16'd7,    16'hFFFE, 16'hFFFD, 16'd1,    1'b0, 16, 17);
    run("s8000",   16'h8000, 16'hFFFF, 16'h8000, 16'd0,    1'b0, 16, 17);
    run("sm7_0",   16'hFFF9, 16'd0,    16'hFFFF, 16'hFFF9, 1'b1, 0, 1);
`else
    run("d5_5",    16'd5,    16'd5,    16'd1,    16'd0,    1'b0, 16, 17);
    run("d8000_ffff", 16'h8000, 16'hFFFF, 16'd0, 16'h8000, 1'b0, 16, 17);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
